spi_bus_arbiter: RTL and testbench
==================================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares the single SPI master port (spi_clk_o/spi_mosi_o/spi_miso_i) between NUM_REQ
//  requesters (6502 SPI register block, boot/config loader, ...). Per-requester chip select.
//  Round-robin arbitration at transaction granularity; integrated mode-0 byte shifter with
//  clock divider. Sits between main_6502 peripherals and the top-level SPI pins.
// PARAMETERS
//  NUM_REQ        2        number of requesters (>=2)
//  CLK_DIV        4        SPI half-period in clk_i cycles (>=1); byte time = 16*CLK_DIV cycles
//  TIMEOUT_CYCLES 4096     idle-hold limit, used only with SPI_ARB_TIMEOUT_EN
// PORTS
//  clk_i       in   1          system clock (one clock domain)
//  reset_ni    in   1          asynchronous, active-low reset
//  req_i       in   NUM_REQ    bus request; held high for the whole multi-byte transaction
//  gnt_o       out  NUM_REQ    one-hot grant
//  tx_valid_i  in   NUM_REQ    byte to send valid (per requester)
//  tx_data_i   in   8*NUM_REQ  flattened tx bytes, requester k at [8k+7:8k]
//  tx_ready_o  out  NUM_REQ    byte accepted when tx_valid_i[k] & tx_ready_o[k]
//  rx_valid_o  out  NUM_REQ    1-cycle pulse: rx_data_o holds the received byte
//  rx_data_o   out  8          received byte (shared; qualified by rx_valid_o)
//  spi_clk_o   out  1          SPI clock, idle low (mode 0)
//  spi_mosi_o  out  1          MSB first
//  spi_miso_i  in   1          sampled on spi_clk_o rising edge
//  spi_cs_no   out  NUM_REQ    per-requester chip select, active low
//  busy_o      out  1          high whenever state != IDLE
//  timeout_o   out  1          1-cycle pulse on forced release (tied 0 without macro)
// BEHAVIOUR
//  - Reset: gnt_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0, spi_clk_o=0, spi_mosi_o=0,
//    spi_cs_no=all 1, busy_o=0, timeout_o=0, RR pointer=0 (req 0 highest after reset).
//    Reset asserted mid-transfer aborts immediately; no rx_valid_o for the partial byte.
//  - FSM: IDLE -> SETUP -> HOLD <-> SHIFT; HOLD -> RELEASE -> IDLE.
//  - IDLE: if any req_i, grant first set bit scanning from pointer upward (wrap). Next cycle:
//    SETUP, gnt_o[k]=1, spi_cs_no[k]=0. Pointer <= k+1 mod NUM_REQ.
//  - SETUP: CLK_DIV cycles CS setup, then HOLD.
//  - HOLD: tx_ready_o[k]=1 (only granted k). tx_valid_i[k] -> latch byte, mosi=bit7,
//    go SHIFT. Else if req_i[k]=0 -> RELEASE. tx_valid_i from non-granted requesters ignored.
//  - SHIFT: 16 half-periods of CLK_DIV cycles; rising edges (odd) sample miso into shift reg,
//    falling edges (even, except last) present next bit. After 16th half-period: spi_clk_o=0,
//    rx_data_o updated, rx_valid_o[k] pulses 1 cycle, back to HOLD. tx_ready_o=0 in SHIFT.
//  - req_i[k] dropped mid-SHIFT: byte completes normally (rx_valid_o pulses), then release.
//  - RELEASE: gnt_o=0, spi_cs_no all 1, CLK_DIV cycles CS deselect gap, then IDLE.
//    A requester still requesting re-arbitrates; same requester may win if alone.
//  - Back-to-back bytes: tx_valid held in HOLD -> next SHIFT starts 1 cycle after rx_valid pulse.
//  - gnt_o and spi_cs_no change only on state entry; never two bits low/high simultaneously.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined: counter runs in HOLD while tx_valid_i[k]=0; at TIMEOUT_CYCLES
//    force RELEASE, pulse timeout_o 1 cycle. Counter clears on every accepted byte.
//  Not defined: HOLD persists indefinitely while req_i[k]=1; timeout_o constant 0, no counter.
// TESTING
//  1 CLK_DIV=2, req0 sends 0xA5, miso looped to mosi -> 8 spi_clk rises, rx_data_o=0xA5,
//    rx_valid_o[0] pulse, cs_no[0] low throughout, SHIFT lasts 32 cycles.
//  2 After reset req=2'b11 same cycle -> gnt 01 first; req0 sends 3 bytes then drops ->
//    RELEASE 2 cycles, then gnt 10; cs_no never 2'b00.
//  3 req0 drops req_i mid-byte (miso=1) -> byte completes, rx_data_o=0xFF, then release.
//  4 reset_ni low during SHIFT bit 4 -> same cycle cs_no=11, spi_clk_o=0, gnt=0, no rx pulse.
//  5 req1 asserts tx_valid_i[1]=1 while req0 granted -> ignored, no tx_ready_o[1], mosi unchanged.
//  6 (macro, TIMEOUT_CYCLES=16) req0 idle in HOLD 16 cycles -> timeout_o pulse, cs_no[0]=1,
//    waiting req1 granted after gap.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one mode-0 SPI master port (with integrated byte shifter) between NUM_REQ requesters.
// Optional macro SPI_ARB_TIMEOUT_EN: force release of a grant left idle in HOLD for TIMEOUT_CYCLES cycles.
module spi_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int CLK_DIV        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [NUM_REQ-1:0]     req_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  input  logic [NUM_REQ-1:0]     tx_valid_i,
  input  logic [8*NUM_REQ-1:0]   tx_data_i,
  output logic [NUM_REQ-1:0]     tx_ready_o,
  output logic [NUM_REQ-1:0]     rx_valid_o,
  output logic [7:0]             rx_data_o,
  output logic                   spi_clk_o,
  output logic                   spi_mosi_o,
  input  logic                   spi_miso_i,
  output logic [NUM_REQ-1:0]     spi_cs_no,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (NUM_REQ < 2 || CLK_DIV < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("spi_bus_arbiter: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, SETUP, HOLD, SHIFT, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      owner_q, ptr_q, win_idx;
  logic               win_found;
  logic [CW-1:0]      cnt_q;
  logic [3:0]         half_q;
  logic [7:0]         tx_sr_q, rx_sr_q, rx_data_q, own_data;
  logic [NUM_REQ-1:0] owner_hot, rx_valid_q;
  logic               spi_clk_q, mosi_q;
  logic               cnt_last, own_req, own_valid, accept, tmo;
  int unsigned        base;

  assign owner_hot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign own_req   = req_i[owner_q];
  assign own_valid = tx_valid_i[owner_q];
  assign own_data  = tx_data_i[{owner_q, 3'b000} +: 8];
  assign cnt_last  = (cnt_q == CW'(CLK_DIV - 1));

  // Grant and chip selects decode the registered state, so they only move on state entry.
  assign gnt_o      = (state_q inside {SETUP, HOLD, SHIFT}) ? owner_hot : '0;
  assign spi_cs_no  = ~gnt_o;
  assign tx_ready_o = (state_q == HOLD) ? owner_hot : '0;
  assign busy_o     = (state_q != IDLE);
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign spi_clk_o  = spi_clk_q;
  assign spi_mosi_o = mosi_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    base      = 32'(ptr_q);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_i[(base + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = PW'((base + i) % NUM_REQ);
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt_q;
  logic          timeout_q;
  logic          tcnt_hit;

  assign tcnt_hit  = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo;
      if (state_q == HOLD && !own_valid) tcnt_q <= tcnt_q + 1'b1;
      else                               tcnt_q <= '0;
    end
  end
`else
  logic tcnt_hit;
  assign tcnt_hit  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE:    if (win_found) state_d = SETUP;
      SETUP:   if (cnt_last) state_d = HOLD;
      HOLD: begin
        if (own_valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else if (!own_req) begin
          state_d = RELEASE;
        end else if (tcnt_hit) begin
          tmo     = 1'b1;
          state_d = RELEASE;
        end
      end
      SHIFT:   if (cnt_last && half_q == 4'd15) state_d = HOLD;
      RELEASE: if (cnt_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      half_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= '0;
      spi_clk_q  <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= '0;
      if (state_q inside {SETUP, SHIFT, RELEASE} && !cnt_last) cnt_q <= cnt_q + 1'b1;
      else                                                     cnt_q <= '0;
      if (state_q == IDLE && win_found) begin
        owner_q <= win_idx;
        ptr_q   <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      if (accept) begin
        tx_sr_q <= own_data;
        mosi_q  <= own_data[7];
      end
      // Even half_q ends with a rising edge (sample), odd with a falling edge (shift out);
      // the last falling edge closes the byte instead of presenting a ninth bit.
      if (state_q != SHIFT) begin
        half_q <= '0;
      end else if (cnt_last) begin
        half_q <= half_q + 1'b1;
        if (!half_q[0]) begin
          spi_clk_q <= 1'b1;
          rx_sr_q   <= {rx_sr_q[6:0], spi_miso_i};
        end else begin
          spi_clk_q <= 1'b0;
          if (half_q == 4'd15) begin
            rx_data_q  <= rx_sr_q;
            rx_valid_q <= owner_hot;
          end else begin
            tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            mosi_q  <= tx_sr_q[6];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter (NUM_REQ=2, CLK_DIV=2).
// With SPI_ARB_TIMEOUT_EN defined the DUT uses TIMEOUT_CYCLES=16 and the timeout scenario is added.
module tb_spi_bus_arbiter;

  localparam int CLK_DIV = 2;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req, gnt, tx_valid, tx_ready, rx_valid, cs_n;
  logic [15:0] tx_data;
  logic [7:0]  rx_data;
  logic        spi_clk, spi_mosi, spi_miso, busy, timeout;
  logic        loop_en, miso_val, cs_bad;

  int   checks = 0;
  int   failures = 0;
  int   rises = 0;
  int   rx0_cnt = 0;
  int   rx1_cnt = 0;
  logic cs_both_low = 1'b0;
  logic clk_prev = 1'b0;

  always #5 clk = ~clk;
  assign spi_miso = loop_en ? spi_mosi : miso_val;

  spi_bus_arbiter #(
    .NUM_REQ(2),
    .CLK_DIV(CLK_DIV),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .reset_ni(reset_n),
    .req_i(req),
    .gnt_o(gnt),
    .tx_valid_i(tx_valid),
    .tx_data_i(tx_data),
    .tx_ready_o(tx_ready),
    .rx_valid_o(rx_valid),
    .rx_data_o(rx_data),
    .spi_clk_o(spi_clk),
    .spi_mosi_o(spi_mosi),
    .spi_miso_i(spi_miso),
    .spi_cs_no(cs_n),
    .busy_o(busy),
    .timeout_o(timeout)
  );

  always @(negedge clk) begin
    clk_prev <= spi_clk;
    if (spi_clk && !clk_prev) rises <= rises + 1;
    if (cs_n == 2'b00) cs_both_low <= 1'b1;
    if (rx_valid[0]) rx0_cnt <= rx0_cnt + 1;
    if (rx_valid[1]) rx1_cnt <= rx1_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (tx_ready[k] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check_eq("ready_wait", 32'(tx_ready[k]), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    check_eq("idle_wait", 32'(busy), 32'd0);
  endtask

  // Sends one byte from requester k (ready assumed high); drop_at>=0 clears req[k] mid-byte.
  task automatic xfer(input int k, input logic [7:0] d, input int drop_at,
                      output logic [7:0] rx, output int cyc);
    tx_data[8*k +: 8] = d;
    tx_valid[k] = 1'b1;
    step();
    tx_valid[k] = 1'b0;
    cyc = 0;
    while (rx_valid[k] !== 1'b1 && cyc < 200) begin
      if (cs_n[k] !== 1'b0) cs_bad = 1'b1;
      if (cyc == drop_at) req[k] = 1'b0;
      step();
      cyc++;
    end
    rx = rx_data;
  endtask

  logic [7:0] rx;
  int         cyc, r0, v0, v1, n;

  initial begin
    req = '0; tx_valid = '0; tx_data = '0;
    loop_en = 1'b1; miso_val = 1'b0; cs_bad = 1'b0;
    reset_n = 1'b0;
    step(); step();
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_cs", 32'(cs_n), 32'h3);
    check_eq("rst_ready", 32'(tx_ready), 32'h0);
    check_eq("rst_rxv", 32'(rx_valid), 32'h0);
    check_eq("rst_rxd", 32'(rx_data), 32'h0);
    check_eq("rst_sclk", 32'(spi_clk), 32'h0);
    check_eq("rst_mosi", 32'(spi_mosi), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_tmo", 32'(timeout), 32'h0);
    reset_n = 1'b1;
    step();

    // Single loopback byte from requester 0
    req = 2'b01;
    step();
    check_eq("t1_gnt", 32'(gnt), 32'h1);
    check_eq("t1_cs", 32'(cs_n), 32'h2);
    check_eq("t1_setup_ready", 32'(tx_ready), 32'h0);
    step(); step();
    check_eq("t1_hold_ready", 32'(tx_ready), 32'h1);
    r0 = rises; v0 = rx0_cnt; cs_bad = 1'b0;
    xfer(0, 8'hA5, -1, rx, cyc);
    check_eq("t1_rx", 32'(rx), 32'hA5);
    check_eq("t1_shift_len", 32'(cyc), 32'd32);
    check_eq("t1_cs_low", 32'(cs_bad), 32'h0);
    req = 2'b00;
    step();
    check_eq("t1_rises", 32'(rises - r0), 32'd8);
    check_eq("t1_rx_pulses", 32'(rx0_cnt - v0), 32'd1);
    check_eq("t1_rel_gnt", 32'(gnt), 32'h0);
    check_eq("t1_rel_cs", 32'(cs_n), 32'h3);
    check_eq("t1_rel_busy", 32'(busy), 32'h1);
    wait_idle();

    // Simultaneous requests after reset, three bytes from req0, then handover
    reset_n = 1'b0;
    step();
    req = 2'b11;
    reset_n = 1'b1;
    step();
    check_eq("t2_first_gnt", 32'(gnt), 32'h1);
    wait_ready(0);
    xfer(0, 8'h3C, -1, rx, cyc);
    check_eq("t2_rx_a", 32'(rx), 32'h3C);
    wait_ready(0);
    xfer(0, 8'h7E, -1, rx, cyc);
    check_eq("t2_rx_b", 32'(rx), 32'h7E);
    wait_ready(0);
    xfer(0, 8'h81, -1, rx, cyc);
    check_eq("t2_rx_c", 32'(rx), 32'h81);

    // Foreign tx_valid while req0 holds the bus
    v1 = rx1_cnt;
    tx_data[15:8] = 8'hFF;
    tx_valid[1] = 1'b1;
    step();
    check_eq("t5_ready", 32'(tx_ready), 32'h1);
    step(); step();
    check_eq("t5_mosi", 32'(spi_mosi), 32'h1);
    check_eq("t5_gnt", 32'(gnt), 32'h1);
    check_eq("t5_sclk", 32'(spi_clk), 32'h0);
    tx_valid[1] = 1'b0;

    req = 2'b10;
    step();
    check_eq("t2_rel_gnt", 32'(gnt), 32'h0);
    step();
    check_eq("t2_rel_busy", 32'(busy), 32'h1);
    step();
    check_eq("t2_idle_busy", 32'(busy), 32'h0);
    step();
    check_eq("t2_second_gnt", 32'(gnt), 32'h2);
    wait_ready(1);
    xfer(1, 8'h5A, -1, rx, cyc);
    check_eq("t2_rx1", 32'(rx), 32'h5A);
    req = 2'b00;
    step();
    check_eq("t5_rx1_pulses", 32'(rx1_cnt - v1), 32'd1);
    wait_idle();
    check_eq("t2_cs_never_both", 32'(cs_both_low), 32'h0);

    // Request dropped mid-byte with miso held high
    loop_en = 1'b0; miso_val = 1'b1;
    req = 2'b01;
    wait_ready(0);
    xfer(0, 8'h00, 10, rx, cyc);
    check_eq("t3_rx", 32'(rx), 32'hFF);
    check_eq("t3_len", 32'(cyc), 32'd32);
    step();
    check_eq("t3_rel_gnt", 32'(gnt), 32'h0);
    check_eq("t3_rel_cs", 32'(cs_n), 32'h3);
    wait_idle();
    loop_en = 1'b1;

    // Asynchronous reset in the middle of a byte
    req = 2'b01;
    wait_ready(0);
    tx_data[7:0] = 8'hFF;
    tx_valid = 2'b01;
    step();
    tx_valid = 2'b00;
    repeat (18) step();
    check_eq("t4_pre_sclk", 32'(spi_clk), 32'h1);
    v0 = rx0_cnt;
    reset_n = 1'b0;
    #1;
    check_eq("t4_cs", 32'(cs_n), 32'h3);
    check_eq("t4_sclk", 32'(spi_clk), 32'h0);
    check_eq("t4_gnt", 32'(gnt), 32'h0);
    check_eq("t4_busy", 32'(busy), 32'h0);
    req = 2'b00;
    step(); step();
    check_eq("t4_no_rx", 32'(rx0_cnt - v0), 32'd0);
    reset_n = 1'b1;
    step();

`ifdef SPI_ARB_TIMEOUT_EN
    // Idle hold times out and the waiting requester takes over
    req = 2'b11;
    wait_ready(0);
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_eq("t6_tmo_cycles", 32'(n), 32'd16);
    check_eq("t6_cs", 32'(cs_n), 32'h3);
    check_eq("t6_gnt", 32'(gnt), 32'h0);
    step();
    check_eq("t6_tmo_pulse", 32'(timeout), 32'h0);
    step(); step();
    check_eq("t6_next_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    wait_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
